// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory load/store path.
// Size codes, LSU state encoding and default memory depth.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int MEM_WORDS_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave is the LSU view, master is the pipeline/memory side.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read, mem_read_addr,
        output mem_write, mem_write_addr, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read, mem_read_addr,
        input  mem_write, mem_write_addr, mem_write_data
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract (with extension) and lane merge for sub-word access.
// Purely combinational; offset 0 is the most significant byte.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sx;

    // ~offset picks the byte lane counted from bit 0
    assign lane_b = word[{~offset, 3'b000} +: 8];
    assign lane_h = offset[1] ? word[15:0] : word[31:16];
    assign sx     = ~is_unsigned;

    always_comb begin
        rdata = word;
        case (size)
            SZ_BYTE: rdata = {{24{sx & lane_b[7]}}, lane_b};
            SZ_HALF: rdata = {{16{sx & lane_h[15]}}, lane_h};
            default: rdata = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{~offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1])
                    merged[15:0] = wdata[15:0];
                else
                    merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: checks a request, sequences read/write strobes,
// extends sub-word loads and read-modify-writes sub-word stores.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    lsu_state_t  state;
    lsu_state_t  next;
    logic        write_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] ext;
    logic [31:0] merged;
    logic        req_err;
    logic        accept;

    assign accept = (state == IDLE) && bus.req_valid;

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.req_addr[0];
            SZ_WORD: req_err = |bus.req_addr[1:0];
            SZ_ILL:  req_err = 1'b1;
        endcase
        if (bus.req_addr >= LIMIT)
            req_err = 1'b1;
    end

    lsu_lane_align u_align (
        .word        (bus.mem_read_data),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (ext),
        .merged      (merged)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        next = RESP;
                    else if (bus.req_write && bus.req_size == SZ_WORD)
                        next = WR_ISSUE;
                    else
                        next = RD_ISSUE;
                end
            end
            RD_ISSUE: next = RD_WAIT;
            RD_WAIT:  next = write_q ? WR_ISSUE : RESP;
            WR_ISSUE: next = RESP;
            RESP:     next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next;
            if (accept) begin
                write_q <= bus.req_write;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
            end
            // wdata_q becomes the full word to write for sub-word stores
            if (state == RD_WAIT) begin
                if (write_q)
                    wdata_q <= merged;
                else
                    rdata_q <= ext;
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = bus.resp_valid ? rdata_q : '0;
    assign bus.resp_error     = bus.resp_valid & err_q;
    assign bus.mem_read       = (state == RD_ISSUE);
    assign bus.mem_read_addr  = bus.mem_read ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_write      = (state == WR_ISSUE);
    assign bus.mem_write_addr = bus.mem_write ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_write_data = bus.mem_write ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random traffic,
// checked every cycle against a cycle-timeline reference model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // memory slave; read data is garbage except the cycle after a read
    logic [31:0] init_mem [32];
    logic [31:0] mem [32];
    logic [31:0] rd_q;
    bit          do_load = 1'b1;

    always @(posedge clk) begin
        if (do_load)
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
        if (bus.mem_read)
            rd_q <= mem[bus.mem_read_addr[6:2]];
        else
            rd_q <= $urandom;
        if (bus.mem_write)
            mem[bus.mem_write_addr[6:2]] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = rd_q;

    // reference model: per request a timeline of k = 1..lat busy cycles
    logic [31:0] ref_mem [32];
    bit          active = 1'b0;
    int          k = 0;
    int          ncyc = 0;
    int          acc_n = 0;
    int          m_lat = 0;
    bit          m_rd, m_wr, m_err;
    logic [31:0] m_addrw, m_rdata, m_wword;
    int          m_idx;

    logic [31:0] got_rdata, got_waddr, got_wdata, got_raddr;
    logic        got_err;
    int          got_lat = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    function automatic void model_accept(input bit w, input int sz,
                                         input bit u, input logic [31:0] a,
                                         input logic [31:0] wd);
        logic [31:0] word, v;
        int off, sh;
        m_err = (sz == 3) || (sz == 1 && a[0]) ||
                (sz == 2 && a[1:0] != 0) || (a >= 128);
        m_lat = m_err ? 1 : (w ? (sz == 2 ? 2 : 4) : 3);
        m_rd  = !m_err && !(w && sz == 2);
        m_wr  = !m_err && w;
        m_addrw = a & 32'hFFFF_FFFC;
        m_idx = int'(a % 128) / 4;
        word = ref_mem[m_idx];
        off = int'(a % 4);
        v = word;
        m_wword = wd;
        if (sz == 0) begin
            sh = 8 * (3 - off);
            v = (word >> sh) & 32'hFF;
            if (!u && v >= 128) v = v - 256;
            m_wword = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (sz == 1) begin
            sh = 16 * (1 - off / 2);
            v = (word >> sh) & 32'hFFFF;
            if (!u && v >= 32768) v = v - 65536;
            m_wword = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        m_rdata = (m_err || w) ? 32'h0 : v;
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (do_load)
            for (int i = 0; i < 32; i++) ref_mem[i] = init_mem[i];
        if (bus.resp_valid) begin
            got_rdata = bus.resp_rdata;
            got_err = bus.resp_error;
            got_lat = ncyc - acc_n;
        end
        if (bus.mem_read) begin
            rd_cnt++;
            got_raddr = bus.mem_read_addr;
        end
        if (bus.mem_write) begin
            wr_cnt++;
            got_waddr = bus.mem_write_addr;
            got_wdata = bus.mem_write_data;
        end
        if (rst) begin
            active = 1'b0;
            chk("rst_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_outs", {bus.resp_valid, bus.mem_read, bus.mem_write},
                32'd0);
        end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(!active));
            chk("resp_valid", 32'(bus.resp_valid),
                32'(active && k == m_lat));
            chk("mem_read", 32'(bus.mem_read), 32'(active && m_rd && k == 1));
            chk("mem_write", 32'(bus.mem_write),
                32'(active && m_wr && k == m_lat - 1));
            if (active && m_rd && k == 1)
                chk("read_addr", bus.mem_read_addr, m_addrw);
            if (active && m_wr && k == m_lat - 1) begin
                chk("write_addr", bus.mem_write_addr, m_addrw);
                chk("write_data", bus.mem_write_data, m_wword);
                ref_mem[m_idx] = m_wword;
            end
            if (active && k == m_lat) begin
                chk("resp_rdata", bus.resp_rdata, m_rdata);
                chk("resp_error", 32'(bus.resp_error), 32'(m_err));
            end
            if (!active) begin
                if (bus.req_valid) begin
                    model_accept(bus.req_write, int'(bus.req_size),
                                 bus.req_unsigned, bus.req_addr,
                                 bus.req_wdata);
                    active = 1'b1;
                    k = 1;
                    acc_n = ncyc;
                end
            end else begin
                k++;
                if (k > m_lat) active = 1'b0;
            end
        end
    end

    task automatic issue(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit noise);
        int n = 0;
        bit acc = 1'b0;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_unsigned = u;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        if (noise) begin
            // held request while busy must be ignored
            bus.req_write = 1'($urandom);
            bus.req_size = 2'($urandom);
            bus.req_addr = $urandom_range(0, 127);
            bus.req_wdata = $urandom;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (active && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("resp_timeout", 32'(n < 30), 32'd1);
    endtask

    task automatic run(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
        issue(w, sz, u, a, wd, 1'b0);
        wait_done();
    endtask

    int r0, w0;
    logic [31:0] saved;
    logic [1:0]  rsz;
    logic [31:0] ra;
    logic [1:0]  err_sz [4];
    logic [31:0] err_a [4];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
        init_mem[1] = 32'h0000_0054;
        init_mem[2] = 32'h0000_000B;
        repeat (3) @(posedge clk);
        #1 do_load = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_mem_read", 32'(bus.mem_read), 32'd0);
        chk("reset_mem_write", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        chk("lw4_lat", 32'(got_lat), 32'd3);
        chk("lw4_data", got_rdata, 32'h0000_0054);
        chk("lw4_err", 32'(got_err), 32'd0);

        r0 = rd_cnt;
        w0 = wr_cnt;
        run(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB);
        chk("sb9_lat", 32'(got_lat), 32'd4);
        chk("sb9_reads", 32'(rd_cnt - r0), 32'd1);
        chk("sb9_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb9_raddr", got_raddr, 32'h8);
        chk("sb9_waddr", got_waddr, 32'h8);
        chk("sb9_wdata", got_wdata, 32'h00AB_000B);

        run(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
        chk("lb9_signed", got_rdata, 32'hFFFF_FFAB);
        run(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        chk("lbu9", got_rdata, 32'h0000_00AB);
        run(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
        chk("lh8", got_rdata, 32'h0000_00AB);

        err_sz[0] = 2'b01; err_a[0] = 32'h5;
        err_sz[1] = 2'b10; err_a[1] = 32'h6;
        err_sz[2] = 2'b10; err_a[2] = 32'h80;
        err_sz[3] = 2'b11; err_a[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            run(1'(i % 2), err_sz[i], 1'b0, err_a[i], 32'h1234_5678);
            chk("err_lat", 32'(got_lat), 32'd1);
            chk("err_flag", 32'(got_err), 32'd1);
            chk("err_rdata", got_rdata, 32'd0);
            chk("err_mem", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        end

        r0 = rd_cnt;
        w0 = wr_cnt;
        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw10_lat", 32'(got_lat), 32'd2);
        chk("sw10_reads", 32'(rd_cnt - r0), 32'd0);
        chk("sw10_writes", 32'(wr_cnt - w0), 32'd1);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw10", got_rdata, 32'hDEAD_BEEF);

        // abort a sub-word store in its read-wait cycle
        saved = mem[5];
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h5A, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_cnt - w0), 32'd0);
        chk("abort_mem", mem[5], saved);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);

        for (int t = 0; t < 300; t++) begin
            rsz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: ra = $urandom;
                1: ra = $urandom_range(120, 135);
                2, 3: ra = $urandom_range(0, 127);
                default: ra = $urandom_range(0, 127) & ~32'(rsz == 2 ? 3 :
                                                         rsz == 1 ? 1 : 0);
            endcase
            issue(1'($urandom), rsz, 1'($urandom), ra, $urandom,
                  1'($urandom_range(0, 3) == 0));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. It accepts one load or store per handshake from the MEM stage and sequences the word-only data memory's read/write strobes. It extracts and sign- or zero-extends sub-word load data, and performs read-modify-write for byte and halfword stores. It sits between the pipeline MEM stage and the 32-word data memory.

## Interface
- MEM_WORDS, 32, number of 32-bit words in the data memory; the valid byte address range is 0 .. MEM_WORDS*4-1.
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  size code: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  qualifies resp_valid; set for misaligned, out-of-range or illegal-size requests.
- mem_read  output  1  memory read strobe.
- mem_read_addr  output  32  word-aligned byte address, {addr[31:2],2'b00}.
- mem_read_data  input  32  memory read data; valid the cycle after mem_read is sampled.
- mem_write  output  1  memory write strobe.
- mem_write_addr  output  32  word-aligned byte address.
- mem_write_data  output  32  full merged word.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP. Outputs are decoded from the registered state (Moore).
- IDLE: req_ready=1. On req_valid, latch all req_* fields and check the request.
  - Error if req_size=11, if a half has addr[0]≠0, if a word has addr[1:0]≠0, or if addr ≥ MEM_WORDS*4. On error go to RESP with resp_error=1.
  - Otherwise a load or a byte/half store goes to RD_ISSUE. A word store goes to WR_ISSUE.
- RD_ISSUE: mem_read=1, mem_read_addr = aligned latched address. Next state is RD_WAIT.
- RD_WAIT: sample mem_read_data.
  - Load: extract lane, extend, register into resp_rdata, go to RESP.
  - Sub-word store: merge req_wdata into the lane of the sampled word, register into mem_write_data, go to WR_ISSUE.
- WR_ISSUE: mem_write=1 with mem_write_addr/mem_write_data. Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle. Next state is IDLE.
- Byte order is big-endian.
  - Byte offset 0 = bits[31:24], offset 3 = bits[7:0].
  - Half offset 0 = bits[31:16], offset 2 = bits[15:0].
- Word store data is passed through unmodified. Word loads are not extended.
- mem_read and mem_write are never high in the same cycle.
- Only one outstanding request. req_valid while not IDLE is ignored (req_ready=0).

## Timing
- Latencies are measured as cycles from the accept edge to the resp_valid-high cycle:
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP. Sustained throughput is therefore at most one request per latency+1 cycles.
- Reset values: state=IDLE, req_ready=1, every other output 0, latched fields 0.
- Reset asserted mid-operation: outputs are forced low immediately. A pending write is never issued. There is no response for the aborted request.
- mem_read_data is used only in RD_WAIT. Its value in any other cycle is ignored.

## Structure
- Shared package mips_mem_pkg:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - The lsu_state_t enum.
  - Default MEM_WORDS.
- Sub-module lsu_lane_align (combinational) provides both directions:
  - extract: word, offset, size, unsigned → rdata.
  - merge: old word, wdata, offset, size → new word.
- The FSM and registers stay in load_store_unit.

## Test plan
- Memory preloaded with word1=0x00000054 and word2=0x0000000B. Load word at 0x4 → resp_valid 3 cycles after accept, resp_rdata=0x00000054, resp_error=0.
- Store byte 0xAB to 0x9 → one mem_read to 0x8, then one mem_write to 0x8 with data 0x00AB000B. resp_valid 4 cycles after accept.
- After the store above, load byte at 0x9:
  - Signed → 0xFFFFFFAB.
  - Unsigned → 0x000000AB.
  - Load half at 0x8, signed → 0x000000AB.
- Each of these requests gives resp_valid with resp_error=1 after 1 cycle, with no mem_read or mem_write pulse:
  - Half at 0x5.
  - Word at 0x6.
  - Word at 0x80 (out of range).
  - req_size=11.
- Store word 0xDEADBEEF to 0x10 → mem_write in the cycle after accept, no mem_read. A following load word at 0x10 returns 0xDEADBEEF.
- Reset asserted during RD_WAIT of a sub-word store → mem_write never pulses, memory word unchanged, req_ready=1 after release.
